// File: rtl/gf2_mul_ds.sv
// Digit-serial carry-less GF(2)[x] multiplier: y = a(x)*b(x), unreduced, with a squaring shortcut.
// Latency: NDIG cycles from accept to out_valid (multiply); square result is valid right after accept.
// Backpressure: single-entry; in_ready only in IDLE, result held in DONE until out_ready.
module gf2_mul_ds #(
  parameter int WIDTH = 9,
  parameter int DIGIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sq,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-2:0]   y
);

  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int BW   = NDIG * DIGIT;
  localparam int PW   = 2 * WIDTH - 1;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [BW-1:0]    b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    y_q, y_d;

  logic [DIGIT-1:0] dig;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    sq_spread;

  // One Horner step: shift the accumulator up a digit and fold in a times the current b digit.
  always_comb begin
    dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    pp  = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (dig[j]) begin
        pp = pp ^ (PW'(a_q) << j);
      end
    end
    acc_step = (acc_q << DIGIT) ^ pp;
  end

  // Squaring over GF(2) has no cross terms: interleave zeros between the coefficients of a.
  always_comb begin
    sq_spread = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sq_spread[2*i] = a[i];
    end
  end

  // Next-state and datapath control; y only changes when a new result is produced.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d             = a;
          b_d             = '0;
          b_d[WIDTH-1:0]  = b;
          acc_d           = '0;
          cnt_d           = CW'(NDIG - 1);
          if (sq) begin
            y_d     = sq_spread;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          y_d     = acc_step;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_gf2_mul_ds.sv
// Bench for gf2_mul_ds: six instances (WIDTH=9 with DIGIT 1,2,3,4,9 and WIDTH=163 with DIGIT=8)
// share one stimulus stream; each result is compared with a shift-and-xor carry-less product model.
// Per-instance monitors check value, latency and that no unrequested result ever appears.
module tb_gf2_mul_ds;

  localparam int NI = 6;
  localparam int N_RAND = 1500;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic out_ready;
  logic sq;
  logic [162:0] a_bus, b_bus;
  logic [NI-1:0] in_rdy, out_vld, done_w;
  logic [324:0] y_all [NI];

  logic [324:0] exp9, exp163;
  logic exp_sq;
  logic quiet;
  int txn_id;
  int cyc;
  int acc_cyc;
  int n_err;
  int n_chk;

  function automatic int dig_of(int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 9;
      default: return 8;
    endcase
  endfunction

  // Carry-less product: xor together shifted copies of x for every set bit of z.
  function automatic logic [324:0] clmul(input logic [162:0] x, input logic [162:0] z);
    logic [324:0] r;
    r = '0;
    for (int i = 0; i < 163; i++) begin
      if (z[i]) r = r ^ (325'(x) << i);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [324:0] got, input logic [324:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W  = (g == 5) ? 163 : 9;
    localparam int D  = dig_of(g);
    localparam int ND = (W + D - 1) / D;
    logic [2*W-2:0] y_w;
    logic [324:0] exp_g;
    logic prev_v;
    int done_id;

    gf2_mul_ds #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_rdy[g]),
      .sq        (sq),
      .a         (a_bus[W-1:0]),
      .b         (b_bus[W-1:0]),
      .out_valid (out_vld[g]),
      .out_ready (out_ready),
      .y         (y_w)
    );

    assign y_all[g]  = 325'(y_w);
    assign exp_g     = (g == 5) ? exp163 : exp9;
    assign done_w[g] = (done_id == txn_id);

    // Each rising out_valid must belong to the current request and carry the right value and latency.
    always @(negedge clk) begin
      if (out_vld[g] && !prev_v) begin
        check($sformatf("g%0d.unexpected", g), 325'({quiet, done_id == txn_id}), 325'(0));
        check($sformatf("g%0d.y", g), y_all[g], exp_g);
        check($sformatf("g%0d.latency", g), 325'(cyc - acc_cyc), exp_sq ? 325'(0) : 325'(ND));
        done_id <= txn_id;
      end
      prev_v <= out_vld[g];
    end
  end

  task automatic start_txn(input logic [162:0] av, input logic [162:0] bv, input logic s,
                           input bit use_fix, input logic [16:0] fix);
    logic [162:0] a9, b9;
    a9 = '0;
    b9 = '0;
    a9[8:0] = av[8:0];
    b9[8:0] = bv[8:0];
    a_bus  = av;
    b_bus  = bv;
    sq     = s;
    exp_sq = s;
    exp163 = s ? clmul(av, av) : clmul(av, bv);
    exp9   = use_fix ? 325'(fix) : (s ? clmul(a9, a9) : clmul(a9, b9));
    txn_id = txn_id + 1;
    quiet  = 1'b0;
    // Accept happens at the next rising edge, which is where cyc becomes cyc+1.
    acc_cyc  = cyc + 1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_w != 6'h3f && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 325'(done_w), 325'(6'h3f));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_rdy != 6'h3f && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 325'(in_rdy), 325'(6'h3f));
  endtask

  task automatic run_fix(input logic [8:0] av, input logic [8:0] bv, input logic s,
                         input logic [16:0] fix);
    start_txn(163'(av), 163'(bv), s, 1'b1, fix);
    wait_done();
    wait_idle();
  endtask

  initial begin
    logic [191:0] ra, rb;
    n_err     = 0;
    n_chk     = 0;
    txn_id    = 0;
    cyc       = 0;
    acc_cyc   = 0;
    quiet     = 1'b1;
    exp9      = '0;
    exp163    = '0;
    exp_sq    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sq        = 1'b0;
    a_bus     = '0;
    b_bus     = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_in_ready", 325'(in_rdy), 325'(6'h3f));
    check("reset_out_valid", 325'(out_vld), 325'(0));
    for (int g = 0; g < NI; g++) check($sformatf("reset_y%0d", g), y_all[g], 325'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed products with known answers.
    run_fix(9'h003, 9'h003, 1'b0, 17'h00005);
    run_fix(9'h1FF, 9'h1FF, 1'b0, 17'h15555);
    run_fix(9'h1FF, 9'h0A3, 1'b1, 17'h15555);
    run_fix(9'h100, 9'h100, 1'b0, 17'h10000);
    run_fix(9'h0A5, 9'h000, 1'b0, 17'h00000);

    // Backpressure: result held while out_ready is low; extra requests are ignored.
    out_ready = 1'b0;
    start_txn(163'h0A5, 163'h13C, 1'b0, 1'b0, 17'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 60 && done_w != 6'h3f; i++) begin
      a_bus = 163'($urandom());
      @(negedge clk);
    end
    check("bp_all_done", 325'(done_w), 325'(6'h3f));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_y_hold", y_all[2], exp9);
      check("bp_out_valid", 325'(out_vld), 325'(6'h3f));
      check("bp_in_ready", 325'(in_rdy), 325'(0));
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle();
    repeat (30) @(negedge clk);

    // Reset in the middle of a multiply aborts it; the next one starts clean.
    start_txn(163'h1FF, 163'h1FF, 1'b0, 1'b0, 17'h0);
    quiet = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 325'(in_rdy), 325'(6'h3f));
    check("abort_out_valid", 325'(out_vld), 325'(0));
    check("abort_y", y_all[2], 325'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run_fix(9'h00F, 9'h011, 1'b0, 17'h000FF);

    // Random operands on all instances; roughly a quarter are squares.
    for (int t = 0; t < N_RAND; t++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      start_txn(ra[162:0], rb[162:0], ($urandom_range(0, 3) == 0), 1'b0, 17'h0);
      wait_done();
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
